// File: rtl/spi_shift.sv
// SPI serial data engine: shifts a parallel-loaded character out on mosi and captures miso
// into the same register, paced by the edge strobes of spi_clgen; reports tip/lstclk back to it.
module spi_shift #(
   parameter int SPI_MAX_CHAR      = 32,
   parameter int SPI_CHAR_LEN_BITS = 5
) (
   input  logic                         wb_clk,
   input  logic                         wb_reset,
   input  logic                         go,
   input  logic                         load,
   input  logic [SPI_MAX_CHAR-1:0]      p_in,
   input  logic [SPI_CHAR_LEN_BITS-1:0] len,
   input  logic                         lsb,
   input  logic                         tx_negedge,
   input  logic                         rx_negedge,
   input  logic                         cpol_0,
   input  logic                         cpol_1,
   input  logic                         miso,
   output logic                         tip,
   output logic                         lstclk,
   output logic                         done,
   output logic [SPI_MAX_CHAR-1:0]      p_out,
   output logic                         mosi
);

   localparam int              CW    = SPI_CHAR_LEN_BITS;
   localparam logic [CW:0]     MAX_N = (CW+1)'(SPI_MAX_CHAR);
   localparam logic [CW:0]     ONE   = (CW+1)'(1);

   logic [SPI_MAX_CHAR-1:0] data_q, data_d;
   logic [CW:0]             n_q, n_d;
   logic [CW:0]             rise_cnt_q, rise_cnt_d;
   logic [CW:0]             fall_cnt_q, fall_cnt_d;
   logic                    lsb_q, lsb_d;
   logic                    txn_q, txn_d;
   logic                    rxn_q, rxn_d;
   logic                    tip_q, tip_d;
   logic                    lstclk_q, lstclk_d;
   logic                    done_q, done_d;
   logic                    mosi_q, mosi_d;

   logic [CW:0]             go_n;
   logic [SPI_MAX_CHAR-1:0] go_src;

   // Map the k-th transmitted bit of an n-bit character onto its register index.
   function automatic logic [CW-1:0] bit_idx(input logic [CW:0] k, input logic [CW:0] n,
                                             input logic lsb_first);
      logic [CW:0] pos;
      pos = lsb_first ? k : (n - ONE - k);
      return pos[CW-1:0];
   endfunction

   assign go_n   = (len == '0) ? MAX_N : {1'b0, len};
   // A same-cycle load must feed the pre-driven first bit.
   assign go_src = load ? p_in : data_q;

   always_comb begin
      data_d     = data_q;
      n_d        = n_q;
      rise_cnt_d = rise_cnt_q;
      fall_cnt_d = fall_cnt_q;
      lsb_d      = lsb_q;
      txn_d      = txn_q;
      rxn_d      = rxn_q;
      tip_d      = tip_q;
      done_d     = 1'b0;
      mosi_d     = mosi_q;

      if (!tip_q) begin
         if (load) begin
            data_d = p_in;
         end
         if (go) begin
            tip_d      = 1'b1;
            n_d        = go_n;
            lsb_d      = lsb;
            txn_d      = tx_negedge;
            rxn_d      = rx_negedge;
            rise_cnt_d = '0;
            fall_cnt_d = '0;
            if (tx_negedge) begin
               mosi_d = go_src[bit_idx('0, go_n, lsb)];
            end
         end
      end else begin
         // Transmit reads always use data_q, so a same-cycle receive write never leaks in.
         if (cpol_0 && (rise_cnt_q < n_q)) begin
            rise_cnt_d = rise_cnt_q + ONE;
            if (!txn_q) begin
               mosi_d = data_q[bit_idx(rise_cnt_q, n_q, lsb_q)];
            end
            if (!rxn_q) begin
               data_d[bit_idx(rise_cnt_q, n_q, lsb_q)] = miso;
            end
         end
         if (cpol_1) begin
            fall_cnt_d = fall_cnt_q + ONE;
            if (txn_q && ((fall_cnt_q + ONE) < n_q)) begin
               mosi_d = data_q[bit_idx(fall_cnt_q + ONE, n_q, lsb_q)];
            end
            if (rxn_q && (fall_cnt_q < n_q)) begin
               data_d[bit_idx(fall_cnt_q, n_q, lsb_q)] = miso;
            end
            if ((fall_cnt_q + ONE) == n_q) begin
               tip_d  = 1'b0;
               done_d = 1'b1;
            end
         end
      end
   end

   logic lst_next;
   assign lst_next = tip_d && (rise_cnt_d == n_d);
   assign lstclk_d = lst_next;

   always_ff @(posedge wb_clk or posedge wb_reset) begin
      if (wb_reset) begin
         data_q     <= '0;
         n_q        <= '0;
         rise_cnt_q <= '0;
         fall_cnt_q <= '0;
         lsb_q      <= 1'b0;
         txn_q      <= 1'b0;
         rxn_q      <= 1'b0;
         tip_q      <= 1'b0;
         lstclk_q   <= 1'b0;
         done_q     <= 1'b0;
         mosi_q     <= 1'b0;
      end else begin
         data_q     <= data_d;
         n_q        <= n_d;
         rise_cnt_q <= rise_cnt_d;
         fall_cnt_q <= fall_cnt_d;
         lsb_q      <= lsb_d;
         txn_q      <= txn_d;
         rxn_q      <= rxn_d;
         tip_q      <= tip_d;
         lstclk_q   <= lstclk_d;
         done_q     <= done_d;
         mosi_q     <= mosi_d;
      end
   end

   assign tip    = tip_q;
   assign lstclk = lstclk_q;
   assign done   = done_q;
   assign p_out  = data_q;
   assign mosi   = mosi_q;

endmodule

// File: tb/tb_spi_shift.sv
// Directed bench for spi_shift driven by a minimal divider=1 clock-generator model;
// expected words are hand-derived from the bit-order, strobe and loopback timing rules.
module tb_spi_shift;

   logic        wb_clk = 1'b0;
   logic        wb_reset, go, load, lsb, tx_negedge, rx_negedge, miso;
   logic        cpol_0, cpol_1;
   logic [31:0] p_in, p_out;
   logic [4:0]  len;
   logic        tip, lstclk, done, mosi;
   logic        loop_en, miso_fix;
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 wb_clk = ~wb_clk;

   assign miso = loop_en ? mosi : miso_fix;

   spi_shift #(.SPI_MAX_CHAR(32), .SPI_CHAR_LEN_BITS(5)) dut (
      .wb_clk(wb_clk), .wb_reset(wb_reset), .go(go), .load(load), .p_in(p_in), .len(len),
      .lsb(lsb), .tx_negedge(tx_negedge), .rx_negedge(rx_negedge), .cpol_0(cpol_0),
      .cpol_1(cpol_1), .miso(miso), .tip(tip), .lstclk(lstclk), .done(done),
      .p_out(p_out), .mosi(mosi)
   );

   // Clock generator stand-in: one strobe every other cycle, no new rise once lstclk is up.
   logic sclk;
   logic div_cnt;
   logic tick;
   assign tick   = tip && div_cnt;
   assign cpol_0 = tick && !sclk && !lstclk;
   assign cpol_1 = tick && sclk;

   always @(posedge wb_clk or posedge wb_reset) begin
      if (wb_reset) begin
         sclk    <= 1'b0;
         div_cnt <= 1'b0;
      end else if (!tip) begin
         div_cnt <= 1'b0;
      end else begin
         div_cnt <= ~div_cnt;
         if (cpol_0)      sclk <= 1'b1;
         else if (cpol_1) sclk <= 1'b0;
      end
   end

   // Bit k is captured where a slave would see it: at rise k (tx on falling) or fall k.
   int          cyc = 0, rise_tot = 0, fall_tot = 0, done_tot = 0, rise_cyc = 0, lst_cyc = 0;
   logic        lst_prev = 1'b0;
   logic        samp_tx_neg = 1'b0;
   logic [31:0] seq = '0;

   always @(negedge wb_clk) begin
      cyc++;
      if (cpol_0) begin
         rise_tot++;
         rise_cyc = cyc;
      end
      if (cpol_1) fall_tot++;
      if (samp_tx_neg ? cpol_0 : cpol_1) seq = {seq[30:0], mosi};
      if (done) done_tot++;
      if (lstclk && !lst_prev) lst_cyc = cyc;
      lst_prev = lstclk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   task automatic nxt;
      @(negedge wb_clk);
      #1;
   endtask

   task automatic start(input logic [4:0] l, input logic [31:0] d, input logic lb,
                        input logic tx, input logic rx);
      len = l; p_in = d; lsb = lb; tx_negedge = tx; rx_negedge = rx;
      samp_tx_neg = tx;
      go = 1'b1; load = 1'b1;
      nxt;
      go = 1'b0; load = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int d0);
      for (int i = 0; i < 3000 && done_tot == d0; i++) nxt;
      check({tag, "_done_seen"}, 32'(done_tot != d0), 32'd1);
      check({tag, "_tip_low_at_done"}, {31'd0, tip}, 32'd0);
   endtask

   task automatic wait_falls(input string tag, input int f0, input int n);
      for (int i = 0; i < 3000 && (fall_tot - f0) < n; i++) nxt;
      check({tag, "_falls_reached"}, 32'(fall_tot - f0), 32'(n));
   endtask

   int r0, f0, d0;

   initial begin
      wb_reset = 1'b1; go = 1'b0; load = 1'b0; p_in = '0; len = '0; lsb = 1'b0;
      tx_negedge = 1'b0; rx_negedge = 1'b0; loop_en = 1'b0; miso_fix = 1'b0;
      repeat (3) nxt;
      check("rst_tip",    {31'd0, tip},    32'd0);
      check("rst_lstclk", {31'd0, lstclk}, 32'd0);
      check("rst_done",   {31'd0, done},   32'd0);
      check("rst_mosi",   {31'd0, mosi},   32'd0);
      check("rst_pout",   p_out,           32'd0);
      wb_reset = 1'b0;
      nxt;

      p_in = 32'h12345678; load = 1'b1;
      nxt;
      load = 1'b0;
      check("idle_load_pout", p_out, 32'h12345678);
      check("idle_load_tip", {31'd0, tip}, 32'd0);

      // Direct loopback, rx on rising: miso is sampled before the new bit launches,
      // so the captured word is the sent stream delayed by one bit (first bit = old mosi 0).
      loop_en = 1'b1;
      r0 = rise_tot; d0 = done_tot;
      start(5'd8, 32'h000000A5, 1'b0, 1'b0, 1'b0);
      wait_done("t1", d0);
      check("t1_lstclk_delay", 32'(lst_cyc - rise_cyc), 32'd1);
      repeat (4) nxt;
      check("t1_rises",     32'(rise_tot - r0), 32'd8);
      check("t1_done_once", 32'(done_tot - d0), 32'd1);
      check("t1_mosi_seq",  {24'd0, seq[7:0]}, 32'h000000A5);
      check("t1_pout",      p_out, 32'h00000052);
      check("t1_sclk_low",  {31'd0, sclk}, 32'd0);
      check("t1_lstclk_clr", {31'd0, lstclk}, 32'd0);

      // Loopback with rx on falling: each bit is sampled after it launches.
      d0 = done_tot;
      start(5'd8, 32'h000000A5, 1'b0, 1'b0, 1'b1);
      wait_done("t1b", d0);
      check("t1b_mosi_seq", {24'd0, seq[7:0]}, 32'h000000A5);
      check("t1b_pout",     p_out, 32'h000000A5);

      // LSB first, tx on falling, miso tied high.
      loop_en = 1'b0; miso_fix = 1'b1;
      d0 = done_tot;
      start(5'd4, 32'h00000003, 1'b1, 1'b1, 1'b0);
      check("t2_predrive", {31'd0, mosi}, 32'd1);
      wait_done("t2", d0);
      check("t2_mosi_seq", {28'd0, seq[3:0]}, 32'h0000000C);
      check("t2_pout",     p_out, 32'h0000000F);

      // len=0 selects a full 32-bit character.
      miso_fix = 1'b0;
      r0 = rise_tot; f0 = fall_tot; d0 = done_tot;
      start(5'd0, 32'h80000001, 1'b0, 1'b0, 1'b0);
      wait_done("t3", d0);
      check("t3_lstclk_delay", 32'(lst_cyc - rise_cyc), 32'd1);
      repeat (4) nxt;
      check("t3_rises",    32'(rise_tot - r0), 32'd32);
      check("t3_falls",    32'(fall_tot - f0), 32'd32);
      check("t3_mosi_seq", seq, 32'h80000001);
      check("t3_pout",     p_out, 32'h00000000);

      // go/load mid-transfer are ignored; bits above the character must keep the original load.
      miso_fix = 1'b1;
      f0 = fall_tot; d0 = done_tot;
      start(5'd4, 32'h00000A5A, 1'b0, 1'b0, 1'b0);
      wait_falls("t5", f0, 2);
      p_in = 32'h000000FF; go = 1'b1; load = 1'b1;
      nxt;
      go = 1'b0; load = 1'b0;
      check("t5_tip_held",  {31'd0, tip}, 32'd1);
      check("t5_upper_mid", {4'd0, p_out[31:4]}, 32'h000000A5);
      wait_done("t5", d0);
      repeat (4) nxt;
      check("t5_done_once", 32'(done_tot - d0), 32'd1);
      check("t5_mosi_seq",  {28'd0, seq[3:0]}, 32'h0000000A);
      check("t5_pout",      p_out, 32'h00000A5F);

      // Reset after three bits aborts without done; a following transfer is clean.
      loop_en = 1'b1;
      f0 = fall_tot; d0 = done_tot;
      start(5'd8, 32'h000000A5, 1'b0, 1'b0, 1'b1);
      wait_falls("t6", f0, 3);
      wb_reset = 1'b1;
      #1;
      check("t6_rst_tip",    {31'd0, tip},    32'd0);
      check("t6_rst_mosi",   {31'd0, mosi},   32'd0);
      check("t6_rst_pout",   p_out,           32'd0);
      check("t6_rst_lstclk", {31'd0, lstclk}, 32'd0);
      nxt;
      wb_reset = 1'b0;
      repeat (10) nxt;
      check("t6_no_done", 32'(done_tot - d0), 32'd0);
      d0 = done_tot;
      start(5'd8, 32'h000000A5, 1'b0, 1'b0, 1'b1);
      wait_done("t6b", d0);
      check("t6b_mosi_seq", {24'd0, seq[7:0]}, 32'h000000A5);
      check("t6b_pout",     p_out, 32'h000000A5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
